mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Encoder side of the single-cycle MIPS control decode path. Turns operation requests plus register/immediate fields into 32-bit MIPS instruction words.
- Each accepted request takes a valid/ready handshake and is written sequentially into instruction memory through a write port with an auto-incrementing address.
- Used as the program loader and instruction-stream generator for the processor and its benches.

Parameters:
- ADDR_W, 6, width of the instruction-memory word address.
- DEPTH, 64, number of words loadable before FULL; must be ≤ 2**ADDR_W and ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: address to 0, leave FULL, clear illegal flag.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept a request.
- op_sel  in  4  operation: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10-15 illegal.
- rs  in  5  source register.
- rt  in  5  second source or destination register.
- rd  in  5  R-type destination register.
- imm  in  16  immediate or branch offset, passed through unchanged.
- target  in  26  jump target field.
- instr_we  out  1  one-cycle memory write strobe.
- instr_addr  out  ADDR_W  word address for the current write.
- instr_word  out  32  encoded instruction.
- full  out  1  DEPTH words written.
- illegal  out  1  sticky: an illegal request was consumed.

Behaviour:
- Reset values: state IDLE, in_ready=1, instr_we=0, instr_addr=0, instr_word=0, full=0, illegal=0.
- States:
  - IDLE: in_ready=1. Handshake = in_valid & in_ready at a rising edge. Fields are captured in that cycle.
    - Legal op → ENCODE.
    - Illegal op → illegal<=1, stay IDLE, no write, address unchanged.
  - ENCODE: in_ready=0. instr_word registered, instr_we=1 this cycle, then → WRITE.
  - WRITE: instr_we=0; instr_addr increments by 1.
    - If the written address was DEPTH-1 → FULL, else → IDLE.
  - FULL: in_ready=0, full=1, instr_addr held at DEPTH-1. Leave only on clear or reset.
- Latency and throughput: handshake at edge N; instr_we high during cycle N+1 with a stable word and address. At most one request per 3 cycles.
- Field layout:
  - R-type: {6'h00, rs, rt, rd, 5'b0, funct}, with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: {opcode, rs, rt, imm}, with lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
  - J-type: {6'h02, target}.
  - Unused input fields are ignored.
- clear:
  - Effective in any state: next state IDLE, instr_addr=0, full=0, illegal=0, instr_we=0.
  - Clear in ENCODE aborts the write in the following cycle; the word in flight is dropped.
  - Clear and a handshake in the same cycle: clear wins, the request is not consumed.
- Reset mid-operation: asynchronously forces all reset values; no partial write may follow.
- instr_word holds its last value outside ENCODE.

Optional Feature:
- Macro: ZERO_DEST_CHECK_EN.
- Defined: R-type with rd==0, or lw/addi with rt==0, is treated as illegal. illegal<=1, no write, state IDLE.
- Undefined: such requests are encoded and written normally; illegal is set only by op_sel 10-15.

Test Plan:
- Reset, then add rs=1 rt=2 rd=3 → cycle after handshake: instr_we=1, addr=0, word=0x00221820. Then sub with the same fields → addr=1, word=0x00221822.
- lw rs=29 rt=8 imm=0x0004 → 0x8FA80004. beq rs=4 rt=5 imm=0xFFFF → 0x1085FFFF. j target=0x0000010 → 0x08000010.
- DEPTH=4, four legal requests → addresses 0,1,2,3, then full=1, in_ready=0, further in_valid ignored. clear → addr=0, full=0, in_ready=1.
- op_sel=12 → illegal=1, no instr_we, addr unchanged. The next legal add still writes at the same addr. clear → illegal=0.
- Assert reset during ENCODE → instr_we=0 immediately, addr=0, no write in following cycles. clear coinciding with in_valid → request not consumed.
- With ZERO_DEST_CHECK_EN: addi rt=0 → illegal=1, no write. Without it: the same request writes 0x20000000 + {rs,imm} fields, illegal=0.

Source files
------------

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder / program loader with sequential imem writes.
// Optional ZERO_DEST_CHECK_EN rejects writes whose destination is $zero.
module mips_instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              instr_we,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_word,
  output logic              full,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENCODE,
    S_WRITE,
    S_FULL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t      state;
  state_t      nxt;
  logic        hs;
  logic        legal;
  logic [5:0]  fn;
  logic [5:0]  opc;
  logic [31:0] enc;

  assign hs = in_valid & in_ready;

  always_comb begin
    fn  = 6'h00;
    opc = 6'h00;
    enc = 32'h0;
    case (op_sel)
      4'd0: fn  = 6'h20;
      4'd1: fn  = 6'h22;
      4'd2: fn  = 6'h24;
      4'd3: fn  = 6'h25;
      4'd4: fn  = 6'h2a;
      4'd5: opc = 6'h23;
      4'd6: opc = 6'h2b;
      4'd7: opc = 6'h04;
      4'd8: opc = 6'h08;
      4'd9: opc = 6'h02;
      default: ;
    endcase
    if (op_sel <= 4'd4)
      enc = {6'h00, rs, rt, rd, 5'b0, fn};
    else if (op_sel == 4'd9)
      enc = {opc, target};
    else
      enc = {opc, rs, rt, imm};
  end

  always_comb begin
    legal = (op_sel <= 4'd9);
`ifdef ZERO_DEST_CHECK_EN
    if (op_sel <= 4'd4 && rd == 5'd0)
      legal = 1'b0;
    if ((op_sel == 4'd5 || op_sel == 4'd8) && rt == 5'd0)
      legal = 1'b0;
`endif
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (hs && legal) nxt = S_ENCODE;
      S_ENCODE: nxt = S_WRITE;
      S_WRITE:  nxt = (instr_addr == LAST) ? S_FULL : S_IDLE;
      S_FULL:   nxt = S_FULL;
      default:  nxt = S_IDLE;
    endcase
    if (clear) nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      instr_addr <= '0;
      instr_word <= 32'h0;
      illegal    <= 1'b0;
    end else begin
      state <= nxt;
      if (clear) begin
        instr_addr <= '0;
        illegal    <= 1'b0;
      end else begin
        if (state == S_IDLE && hs && !legal)
          illegal <= 1'b1;
        if (state == S_IDLE && hs && legal)
          instr_word <= enc;
        if (state == S_WRITE && instr_addr != LAST)
          instr_addr <= instr_addr + 1'b1;
      end
    end
  end

  // clear during ENCODE drops the in-flight word
  assign instr_we = (state == S_ENCODE) && !clear;
  assign in_ready = (state == S_IDLE);
  assign full     = (state == S_FULL);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomised self-checking bench for mips_instr_encoder (DEPTH=4).
// Reference model encodes from opcode tables and tracks the write pointer.
module tb_mips_instr_encoder;

  localparam int AW = 3;
  localparam int DP = 4;

  logic          clk = 0;
  logic          reset = 1;
  logic          clear = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [3:0]    op_sel = 0;
  logic [4:0]    rs = 0, rt = 0, rd = 0;
  logic [15:0]   imm = 0;
  logic [25:0]   target = 0;
  logic          instr_we;
  logic [AW-1:0] instr_addr;
  logic [31:0]   instr_word;
  logic          full;
  logic          illegal;

  int errors = 0;
  int checks = 0;

  int m_addr = 0;
  bit m_full = 0;
  bit m_ill  = 0;

  mips_instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target),
    .instr_we(instr_we), .instr_addr(instr_addr),
    .instr_word(instr_word), .full(full),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(
    input int op, input int s, input int t,
    input int d, input int im, input int tg);
    int opc[10] = '{0, 0, 0, 0, 0, 'h23, 'h2b, 'h04, 'h08, 'h02};
    int fnc[5]  = '{'h20, 'h22, 'h24, 'h25, 'h2a};
    longint w;
    if (op < 5)
      w = s * (2**21) + t * (2**16) + d * (2**11) + fnc[op];
    else if (op == 9)
      w = longint'(opc[op]) * (2**26) + tg;
    else
      w = longint'(opc[op]) * (2**26) + s * (2**21)
        + t * (2**16) + im;
    return w[31:0];
  endfunction

  function automatic bit ref_legal(input int op, input int t,
                                   input int d);
    if (op > 9) return 0;
`ifdef ZERO_DEST_CHECK_EN
    if (op < 5 && d == 0) return 0;
    if ((op == 5 || op == 8) && t == 0) return 0;
`endif
    return 1;
  endfunction

  task automatic model_clear();
    m_addr = 0;
    m_full = 0;
    m_ill  = 0;
  endtask

  // Returns expected strobe/address/word and advances the model.
  task automatic model_req(
    input int op, input int s, input int t, input int d,
    input int im, input int tg,
    output bit ewe, output int ea, output logic [31:0] ew);
    ewe = 0;
    ea  = m_addr;
    ew  = 32'h0;
    if (m_full) return;
    if (!ref_legal(op, t, d)) begin
      m_ill = 1;
      return;
    end
    ewe = 1;
    ew  = ref_word(op, s, t, d, im, tg);
    if (m_addr == DP - 1) m_full = 1;
    else m_addr++;
  endtask

  task automatic drive(
    input logic [3:0] op, input logic [4:0] s, t, d,
    input logic [15:0] im, input logic [25:0] tg,
    output logic we1, output logic [AW-1:0] a1,
    output logic [31:0] w1, output logic we2,
    output logic fl, output logic il, output logic rdy);
    @(negedge clk);
    op_sel = op; rs = s; rt = t; rd = d;
    imm = im; target = tg;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    we1 = instr_we; a1 = instr_addr; w1 = instr_word;
    @(negedge clk);
    we2 = instr_we;
    @(posedge clk);
    #1;
    fl = full; il = illegal; rdy = in_ready;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
    model_clear();
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1 || instr_we !== 0 || instr_addr !== 0 ||
        instr_word !== 0 || full !== 0 || illegal !== 0) begin
      errors++;
      $display("FAIL reset: rdy=%b we=%b a=%0d w=%h f=%b i=%b want 1 0 0 0 0 0",
               in_ready, instr_we, instr_addr, instr_word, full, illegal);
    end
  endtask

  task automatic test_directed();
    logic we1, we2, fl, il, rdy;
    logic [AW-1:0] a1;
    logic [31:0] w1;
    logic [31:0] exp_w[5] = '{32'h00221820, 32'h00221822,
                              32'h8fa80004, 32'h1085ffff,
                              32'h08000010};
    int exp_a[5] = '{0, 1, 0, 1, 2};
    do_clear();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) do_clear();
      case (i)
        0: drive(4'd0, 1, 2, 3, 16'h0, 26'h0,
                 we1, a1, w1, we2, fl, il, rdy);
        1: drive(4'd1, 1, 2, 3, 16'h0, 26'h0,
                 we1, a1, w1, we2, fl, il, rdy);
        2: drive(4'd5, 29, 8, 0, 16'h0004, 26'h0,
                 we1, a1, w1, we2, fl, il, rdy);
        3: drive(4'd7, 4, 5, 0, 16'hffff, 26'h0,
                 we1, a1, w1, we2, fl, il, rdy);
        default: drive(4'd9, 0, 0, 0, 16'h0, 26'h10,
                       we1, a1, w1, we2, fl, il, rdy);
      endcase
      checks++;
      if (we1 !== 1 || a1 !== AW'(exp_a[i]) || w1 !== exp_w[i] ||
          we2 !== 0) begin
        errors++;
        $display("FAIL directed%0d: we=%b a=%0d w=%h we2=%b want 1 %0d %h 0",
                 i, we1, a1, w1, we2, exp_a[i], exp_w[i]);
      end
    end
    do_clear();
  endtask

  task automatic test_full();
    logic we1, we2, fl, il, rdy;
    logic [AW-1:0] a1;
    logic [31:0] w1;
    do_clear();
    for (int i = 0; i < DP; i++) begin
      drive(4'd3, 5'(i + 1), 7, 9, 16'h0, 26'h0,
            we1, a1, w1, we2, fl, il, rdy);
      checks++;
      if (we1 !== 1 || a1 !== AW'(i)) begin
        errors++;
        $display("FAIL fill%0d: we=%b a=%0d want 1 %0d",
                 i, we1, a1, i);
      end
    end
    checks++;
    if (fl !== 1 || rdy !== 0 || instr_addr !== AW'(DP - 1)) begin
      errors++;
      $display("FAIL full_state: f=%b rdy=%b a=%0d want 1 0 %0d",
               fl, rdy, instr_addr, DP - 1);
    end
    drive(4'd0, 1, 2, 3, 16'h0, 26'h0,
          we1, a1, w1, we2, fl, il, rdy);
    checks++;
    if (we1 !== 0 || we2 !== 0 || fl !== 1) begin
      errors++;
      $display("FAIL full_ignore: we=%b we2=%b f=%b want 0 0 1",
               we1, we2, fl);
    end
    do_clear();
    checks++;
    if (instr_addr !== 0 || full !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL full_clear: a=%0d f=%b rdy=%b want 0 0 1",
               instr_addr, full, in_ready);
    end
  endtask

  task automatic test_illegal();
    logic we1, we2, fl, il, rdy;
    logic [AW-1:0] a1;
    logic [31:0] w1;
    do_clear();
    drive(4'd0, 1, 2, 3, 16'h0, 26'h0,
          we1, a1, w1, we2, fl, il, rdy);
    drive(4'd12, 1, 2, 3, 16'h0, 26'h0,
          we1, a1, w1, we2, fl, il, rdy);
    checks++;
    if (we1 !== 0 || we2 !== 0 || il !== 1 ||
        instr_addr !== 1) begin
      errors++;
      $display("FAIL illegal_op: we=%b il=%b a=%0d want 0 1 1",
               we1, il, instr_addr);
    end
    drive(4'd0, 4, 5, 6, 16'h0, 26'h0,
          we1, a1, w1, we2, fl, il, rdy);
    checks++;
    if (we1 !== 1 || a1 !== 1 || w1 !== 32'h00853020) begin
      errors++;
      $display("FAIL illegal_next: we=%b a=%0d w=%h want 1 1 00853020",
               we1, a1, w1);
    end
    do_clear();
    checks++;
    if (illegal !== 0) begin
      errors++;
      $display("FAIL illegal_clear: il=%b want 0", illegal);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_clear();
    @(negedge clk);
    op_sel = 0; rs = 1; rt = 2; rd = 3;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    checks++;
    if (instr_we !== 1) begin
      errors++;
      $display("FAIL rst_pre: we=%b want 1", instr_we);
    end
    reset = 1;
    #1;
    checks++;
    if (instr_we !== 0 || instr_addr !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL rst_mid: we=%b a=%0d rdy=%b want 0 0 1",
               instr_we, instr_addr, in_ready);
    end
    @(negedge clk);
    reset = 0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (instr_we !== 0) seen = 1;
    end
    checks++;
    if (seen || instr_addr !== 0) begin
      errors++;
      $display("FAIL rst_after: write=%b a=%0d want 0 0",
               seen, instr_addr);
    end
  endtask

  task automatic test_clear_hs();
    bit seen = 0;
    do_clear();
    @(negedge clk);
    op_sel = 1; rs = 3; rt = 4; rd = 5;
    in_valid = 1;
    clear = 1;
    @(posedge clk);
    #1 clear = 0;
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (instr_we !== 0) seen = 1;
    end
    checks++;
    if (seen || instr_addr !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL clear_hs: write=%b a=%0d rdy=%b want 0 0 1",
               seen, instr_addr, in_ready);
    end
  endtask

  task automatic test_zero_dest();
    logic we1, we2, fl, il, rdy;
    logic [AW-1:0] a1;
    logic [31:0] w1;
    do_clear();
    drive(4'd8, 3, 0, 0, 16'h1234, 26'h0,
          we1, a1, w1, we2, fl, il, rdy);
    checks++;
`ifdef ZERO_DEST_CHECK_EN
    if (we1 !== 0 || il !== 1) begin
      errors++;
      $display("FAIL zero_dest: we=%b il=%b want 0 1", we1, il);
    end
`else
    if (we1 !== 1 || a1 !== 0 || w1 !== 32'h20601234 ||
        il !== 0) begin
      errors++;
      $display("FAIL zero_dest: we=%b a=%0d w=%h il=%b want 1 0 20601234 0",
               we1, a1, w1, il);
    end
`endif
    do_clear();
  endtask

  task automatic test_random();
    logic we1, we2, fl, il, rdy;
    logic [AW-1:0] a1;
    logic [31:0] w1;
    bit ewe;
    int ea;
    logic [31:0] ew;
    int op, s, t, d, im, tg;
    do_clear();
    for (int n = 0; n < 60; n++) begin
      if (m_full || $urandom_range(0, 9) == 0) do_clear();
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) op = $urandom_range(0, 9);
      s  = $urandom_range(0, 31);
      t  = $urandom_range(0, 31);
      d  = $urandom_range(0, 31);
      im = $urandom_range(0, 65535);
      tg = $urandom_range(0, (1 << 26) - 1);
      model_req(op, s, t, d, im, tg, ewe, ea, ew);
      drive(4'(op), 5'(s), 5'(t), 5'(d), 16'(im), 26'(tg),
            we1, a1, w1, we2, fl, il, rdy);
      checks++;
      if (we1 !== ewe || we2 !== 0 ||
          (ewe && (a1 !== AW'(ea) || w1 !== ew)) ||
          fl !== m_full || il !== m_ill) begin
        errors++;
        $display("FAIL rand%0d op=%0d: we=%b a=%0d w=%h f=%b i=%b want %b %0d %h %b %b",
                 n, op, we1, a1, w1, fl, il,
                 ewe, ea, ew, m_full, m_ill);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 0;
    test_directed();
    test_full();
    test_illegal();
    test_reset_mid();
    test_clear_hs();
    test_zero_dest();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
